// File: rtl/wb_sram_pkg.sv
// Shared types and defaults for the Wishbone bridges in front of the 32x512 OpenRAM macro.
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } state_t;

  localparam int          SRAM_ADDR_WIDTH = 9;
  localparam int          SRAM_DATA_WIDTH = 32;
  localparam int          SRAM_NUM_WMASKS = 4;
  localparam logic [31:0] SRAM_BASE_ADDR  = 32'h3000_0000;

endpackage

// File: rtl/wb_sram_port0_bridge_if.sv
// Wishbone slave signals plus macro port-0 pins; slave = bridge side, master = bus/macro side.
interface wb_sram_port0_bridge_if
  import wb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS
);
  logic                  wbs_cyc_i;
  logic                  wbs_stb_i;
  logic                  wbs_we_i;
  logic [NUM_WMASKS-1:0] wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [DATA_WIDTH-1:0] wbs_dat_i;
  logic                  wbs_ack_o;
  logic                  wbs_err_o;
  logic [DATA_WIDTH-1:0] wbs_dat_o;

  logic                  sram_csb0;
  logic                  sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0;
  logic [DATA_WIDTH-1:0] sram_dout0;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, sram_dout0,
    output wbs_ack_o, wbs_err_o, wbs_dat_o,
    output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, sram_dout0,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o,
    input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
  );

endinterface

// File: rtl/wb_sram_addr_decode.sv
// Combinational window decode for a 32-bit byte address: hit, word address, misalign, 64 KiB guard.
module wb_sram_addr_decode
  import wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = SRAM_BASE_ADDR,
  parameter int          ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
  input  logic [31:0]           adr,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  misalign,
  output logic                  in_guard
);

  assign hit       = (adr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign word_addr = adr[ADDR_WIDTH+1:2];
  assign misalign  = |adr[1:0];
  assign in_guard  = (adr[31:16] == BASE_ADDR[31:16]);

endmodule

// File: rtl/wb_sram_port0_bridge.sv
// Wishbone B4 classic slave driving port 0 of sky130_sram_2kbyte_1rw1r_32x512_8.
// Optional WB_SRAM_BRIDGE_ERR_EN: err on guard-window misses and misaligned accesses.
//
// state   | meaning
// IDLE    | accepting a new request; macro pins follow the bus
// RD_WAIT | read captured by macro, waiting for negedge-valid dout
// ACK     | ack (or err) high for this single cycle; macro deselected
module wb_sram_port0_bridge
  import wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = SRAM_BASE_ADDR,
  parameter int          ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int          DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int          NUM_WMASKS = SRAM_NUM_WMASKS
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  wb_sram_port0_bridge_if.slave bus
);

  logic                  hit;
  logic                  misalign;
  logic                  in_guard;
  logic [ADDR_WIDTH-1:0] word_addr;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  stb_idle;
  logic                  req;
  logic                  err_req;

  wb_sram_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .adr       (bus.wbs_adr_i),
    .hit       (hit),
    .word_addr (word_addr),
    .misalign  (misalign),
    .in_guard  (in_guard)
  );

  // Gating with reset keeps the macro deselected while reset is held, even if the bus is busy.
  assign stb_idle = bus.wbs_cyc_i & bus.wbs_stb_i & (state_q == IDLE) & ~wb_rst_i;

`ifdef WB_SRAM_BRIDGE_ERR_EN
  assign req     = stb_idle & hit & ~misalign;
  assign err_req = stb_idle & ((in_guard & ~hit) | (hit & misalign));
`else
  logic unused_err_decode;
  assign unused_err_decode = misalign ^ in_guard;
  assign req     = stb_idle & hit;
  assign err_req = 1'b0;
`endif

  assign bus.sram_csb0   = ~req;
  assign bus.sram_web0   = ~(req & bus.wbs_we_i);
  assign bus.sram_wmask0 = (req & bus.wbs_we_i) ? bus.wbs_sel_i : '0;
  assign bus.sram_addr0  = word_addr;
  assign bus.sram_din0   = bus.wbs_dat_i;

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_err_o = err_q;
  assign bus.wbs_dat_o = dat_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (bus.wbs_we_i) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (err_req) begin
          state_d = ACK;
          err_d   = 1'b1;
        end
      end
      RD_WAIT: begin
        // Dropping cyc here abandons the read; the captured macro read is simply ignored.
        if (bus.wbs_cyc_i) begin
          dat_d   = bus.sram_dout0;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_sram_port0_bridge.sv
// Directed bench for wb_sram_port0_bridge with a behavioural model of the macro's port 0.
module tb_wb_sram_port0_bridge;
  import wb_sram_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic wb_clk_i;
  logic wb_rst_i;
  int   n_cmp;
  int   n_mis;
  int   acc_cnt;
  int   acc_start;

  wb_sram_port0_bridge_if bus ();

  wb_sram_port0_bridge dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Macro model: inputs registered on posedge, read data valid after the following negedge.
  logic [31:0] mem [0:511];
  logic        rd_pend;
  logic [8:0]  rd_addr;

  initial begin
    rd_pend        = 1'b0;
    rd_addr        = '0;
    bus.sram_dout0 = '0;
    acc_cnt        = 0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0]   = 32'hCAFE_F00D;
    mem[8]   = 32'h5555_AAAA;
    mem[511] = 32'h1234_5678;
  end

  always @(posedge wb_clk_i) begin
    rd_pend <= ~bus.sram_csb0 & bus.sram_web0;
    rd_addr <= bus.sram_addr0;
    if (!bus.sram_csb0) begin
      acc_cnt <= acc_cnt + 1;
      if (!bus.sram_web0)
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask0[b]) mem[bus.sram_addr0][8*b +: 8] <= bus.sram_din0[8*b +: 8];
    end
  end

  always @(negedge wb_clk_i)
    if (rd_pend) bus.sram_dout0 <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drop();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
  endtask

  task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    drive(1'b1, adr, dat, sel);
    #1;
    chk({tag, "_c0_csb"},   bus.sram_csb0, 32'd0);
    chk({tag, "_c0_web"},   bus.sram_web0, 32'd0);
    chk({tag, "_c0_addr"},  bus.sram_addr0, 32'(adr[10:2]));
    chk({tag, "_c0_wmask"}, bus.sram_wmask0, 32'(sel));
    chk({tag, "_c0_din"},   bus.sram_din0, dat);
    chk({tag, "_c0_ack"},   bus.wbs_ack_o, 32'd0);
    step();
    chk({tag, "_c1_ack"},   bus.wbs_ack_o, 32'd1);
    chk({tag, "_c1_csb"},   bus.sram_csb0, 32'd1);
    drop();
    step();
    chk({tag, "_c2_ack"},   bus.wbs_ack_o, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    drive(1'b0, adr, 32'h0, 4'hF);
    #1;
    chk({tag, "_c0_csb"},   bus.sram_csb0, 32'd0);
    chk({tag, "_c0_web"},   bus.sram_web0, 32'd1);
    chk({tag, "_c0_wmask"}, bus.sram_wmask0, 32'd0);
    step();
    chk({tag, "_c1_ack"},   bus.wbs_ack_o, 32'd0);
    chk({tag, "_c1_csb"},   bus.sram_csb0, 32'd1);
    step();
    chk({tag, "_c2_ack"},   bus.wbs_ack_o, 32'd1);
    chk({tag, "_c2_dat"},   bus.wbs_dat_o, exp);
    drop();
    step();
    chk({tag, "_c3_ack"},   bus.wbs_ack_o, 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    wb_rst_i = 1'b0;
    drop();
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;

    // Reset asserted between edges
    #2 wb_rst_i = 1'b1;
    #1;
    chk("rst_csb",   bus.sram_csb0, 32'd1);
    chk("rst_web",   bus.sram_web0, 32'd1);
    chk("rst_wmask", bus.sram_wmask0, 32'd0);
    chk("rst_ack",   bus.wbs_ack_o, 32'd0);
    chk("rst_err",   bus.wbs_err_o, 32'd0);
    chk("rst_dat",   bus.wbs_dat_o, 32'd0);
    step();
    step();
    wb_rst_i = 1'b0;

    // Full write then readback
    do_write("wr_full", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_read ("rd_full", BASE + 32'h10, 32'hDEAD_BEEF);

    // Partial write of byte lane 1
    do_write("wr_part", BASE + 32'h10, 32'h0000_AB00, 4'b0010);
    do_read ("rd_part", BASE + 32'h10, 32'hDEAD_ABEF);

    // sel=0 write is issued and acked but leaves memory intact
    do_write("wr_sel0", BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000);
    do_read ("rd_sel0", BASE + 32'h10, 32'hDEAD_ABEF);

    // Back-to-back reads, stb held: word 511 then word 0
    acc_start = acc_cnt;
    drive(1'b0, BASE + 32'h7FC, 32'h0, 4'hF);
    #1;
    chk("b2b_c0_csb",  bus.sram_csb0, 32'd0);
    chk("b2b_c0_addr", bus.sram_addr0, 32'd511);
    step();
    chk("b2b_c1_csb",  bus.sram_csb0, 32'd1);
    chk("b2b_c1_ack",  bus.wbs_ack_o, 32'd0);
    step();
    chk("b2b_c2_ack",  bus.wbs_ack_o, 32'd1);
    chk("b2b_c2_dat",  bus.wbs_dat_o, 32'h1234_5678);
    chk("b2b_c2_csb",  bus.sram_csb0, 32'd1);
    bus.wbs_adr_i = BASE;
    #1;
    chk("b2b_ack_csb", bus.sram_csb0, 32'd1);
    step();
    chk("b2b_c3_ack",  bus.wbs_ack_o, 32'd0);
    chk("b2b_c3_csb",  bus.sram_csb0, 32'd0);
    chk("b2b_c3_addr", bus.sram_addr0, 32'd0);
    step();
    chk("b2b_c4_csb",  bus.sram_csb0, 32'd1);
    chk("b2b_c4_ack",  bus.wbs_ack_o, 32'd0);
    step();
    chk("b2b_c5_ack",  bus.wbs_ack_o, 32'd1);
    chk("b2b_c5_dat",  bus.wbs_dat_o, 32'hCAFE_F00D);
    drop();
    step();
    chk("b2b_c6_ack",  bus.wbs_ack_o, 32'd0);
    chk("b2b_accesses", 32'(acc_cnt - acc_start), 32'd2);

    // Read aborted by dropping cyc during RD_WAIT
    drive(1'b0, BASE + 32'h20, 32'h0, 4'hF);
    step();
    drop();
    step();
    chk("abort_ack", bus.wbs_ack_o, 32'd0);
    chk("abort_dat", bus.wbs_dat_o, 32'hCAFE_F00D);
    drive(1'b0, BASE + 32'h7FC, 32'h0, 4'hF);
    #1;
    chk("abort_idle_csb", bus.sram_csb0, 32'd0);
    step();
    step();
    chk("abort_next_ack", bus.wbs_ack_o, 32'd1);
    chk("abort_next_dat", bus.wbs_dat_o, 32'h1234_5678);
    drop();
    step();

    // Access just outside the SRAM window, inside the guard window
    drive(1'b0, BASE + 32'h800, 32'h0, 4'hF);
    #1;
    chk("miss_c0_csb", bus.sram_csb0, 32'd1);
    step();
    chk("miss_c1_ack", bus.wbs_ack_o, 32'd0);
`ifdef WB_SRAM_BRIDGE_ERR_EN
    chk("miss_c1_err", bus.wbs_err_o, 32'd1);
    drop();
    step();
    chk("miss_c2_err", bus.wbs_err_o, 32'd0);
`else
    chk("miss_c1_err", bus.wbs_err_o, 32'd0);
    step();
    chk("miss_c2_ack", bus.wbs_ack_o, 32'd0);
    chk("miss_c2_csb", bus.sram_csb0, 32'd1);
    drop();
    step();
`endif

    // Misaligned access to word 4
`ifdef WB_SRAM_BRIDGE_ERR_EN
    drive(1'b0, BASE + 32'h12, 32'h0, 4'hF);
    #1;
    chk("mis_c0_csb", bus.sram_csb0, 32'd1);
    step();
    chk("mis_c1_err", bus.wbs_err_o, 32'd1);
    chk("mis_c1_ack", bus.wbs_ack_o, 32'd0);
    drop();
    step();
`else
    do_read("mis_rd", BASE + 32'h12, 32'hDEAD_ABEF);
`endif

    // Reset mid-cycle while a write request is on the bus
    drive(1'b1, BASE + 32'h40, 32'h0BAD_0BAD, 4'hF);
    #1;
    chk("mrst_pre_csb", bus.sram_csb0, 32'd0);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("mrst_csb",   bus.sram_csb0, 32'd1);
    chk("mrst_web",   bus.sram_web0, 32'd1);
    chk("mrst_wmask", bus.sram_wmask0, 32'd0);
    chk("mrst_ack",   bus.wbs_ack_o, 32'd0);
    chk("mrst_dat",   bus.wbs_dat_o, 32'd0);
    step();
    wb_rst_i = 1'b0;
    drop();
    step();
    do_read("post_rst", BASE + 32'h7FC, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
